// File: rtl/busresponder_if.sv
// rtl/busresponder_if.sv - load/store bus between an initiator and busresponder
interface busresponder_if;
  logic        req_le;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_ctrl;
  logic        resp_busy;
  logic [31:0] resp_odata;
  logic        resp_err;

  modport master (
    output req_le, req_we, req_addr, req_wdata, req_ctrl,
    input  resp_busy, resp_odata, resp_err
  );

  modport slave (
    input  req_le, req_we, req_addr, req_wdata, req_ctrl,
    output resp_busy, resp_odata, resp_err
  );
endinterface

// File: rtl/busresponder.sv
// rtl/busresponder.sv - latency-modelled RAM responder for the load/store bus
// Optional misaligned-access trap: BUSRESP_MISALIGN_TRAP_EN.
module busresponder #(
  parameter int ADDR_WIDTH = 14,
  parameter int LATENCY    = 2
) (
  input  logic          CLK,
  input  logic          RST_X,
  busresponder_if.slave bus
);
  localparam int AW = ADDR_WIDTH + 2;
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t          state, state_next;
  logic [3:0]      cnt;
  logic [AW-1:0]   addr_q;
  logic [2:0]      ctrl_q;
  logic [31:0]     wdata_q;
  logic            rd_q;
  logic            busy_q;
  logic [31:0]     odata_q;
  logic            accept, execute, done;
  logic            op_ok;
  logic [1:0]      lane;
  logic [3:0]      be;
  logic [31:0]     wshift, rword, rext;
  logic [ADDR_WIDTH-1:0] widx;
  logic            unused_addr_hi;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  assign unused_addr_hi = ^bus.req_addr[31:AW];

`ifdef BUSRESP_MISALIGN_TRAP_EN
  logic err_q;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'b01 && a[0]) || (size[1] && a != 2'b00);
  endfunction

  assign op_ok        = !err_q;
  assign bus.resp_err = err_q;
`else
  assign op_ok        = 1'b1;
  assign bus.resp_err = 1'b0;
`endif

  // Misaligned halves/words are aligned down; the trap build suppresses them instead.
  assign lane = (ctrl_q[1:0] == 2'b00) ? addr_q[1:0] :
                (ctrl_q[1:0] == 2'b01) ? {addr_q[1], 1'b0} : 2'b00;
  assign widx  = addr_q[AW-1:2];
  assign rword = mem[widx] >> {lane, 3'b000};

  always_comb begin
    be     = 4'b1111;
    wshift = wdata_q;
    rext   = rword;
    unique case (ctrl_q[1:0])
      2'b00: begin
        be     = 4'b0001 << lane;
        wshift = {24'h0, wdata_q[7:0]} << {lane, 3'b000};
        rext   = {{24{~ctrl_q[2] & rword[7]}}, rword[7:0]};
      end
      2'b01: begin
        be     = 4'b0011 << lane;
        wshift = {16'h0, wdata_q[15:0]} << {lane, 3'b000};
        rext   = {{16{~ctrl_q[2] & rword[15]}}, rword[15:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    execute    = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: if (bus.req_le || bus.req_we) begin
        accept     = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: if (cnt == 4'd1) begin
        execute    = 1'b1;
        state_next = RELEASE;
      end
      RELEASE: if (!bus.req_le && !bus.req_we) begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      cnt     <= 4'd0;
      addr_q  <= '0;
      ctrl_q  <= 3'b000;
      wdata_q <= 32'h0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      odata_q <= 32'h0;
`ifdef BUSRESP_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr[AW-1:0];
        ctrl_q  <= bus.req_ctrl;
        wdata_q <= bus.req_wdata;
        rd_q    <= bus.req_le;
        cnt     <= LAT;
        busy_q  <= 1'b1;
`ifdef BUSRESP_MISALIGN_TRAP_EN
        err_q   <= is_misaligned(bus.req_ctrl[1:0], bus.req_addr[1:0]);
`endif
      end
      if (state == ACCESS) cnt <= cnt - 4'd1;
      if (execute && rd_q) odata_q <= op_ok ? rext : 32'h0;
      if (done) begin
        busy_q <= 1'b0;
`ifdef BUSRESP_MISALIGN_TRAP_EN
        err_q  <= 1'b0;
`endif
      end
    end
  end

  // RAM is not reset; a reset before the execute edge leaves state IDLE so the write never lands.
  always_ff @(posedge CLK) begin
    if (execute && !rd_q && op_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wshift[8*i +: 8];
      end
    end
  end

  assign bus.resp_busy  = busy_q;
  assign bus.resp_odata = odata_q;
endmodule
